// File: rtl/rle_stream_encoder_if.sv
// Symbol-in / record-out handshake bundle for the run-length encoder.
// The slave modport is the encoder's view of the bundle; the master modport is the environment's view.
`timescale 1ns/1ps
interface rle_stream_encoder_if #(
  parameter int SYM_W = 8,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [SYM_W-1:0] in_sym;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [SYM_W-1:0] out_sym;
  logic [CNT_W-1:0] out_cnt;
  logic             out_last;

  modport slave (
    input  in_valid, in_sym, in_last, out_ready,
    output in_ready, out_valid, out_sym, out_cnt, out_last
  );

  modport master (
    output in_valid, in_sym, in_last, out_ready,
    input  in_ready, out_valid, out_sym, out_cnt, out_last
  );
endinterface

// File: rtl/rle_stream_encoder.sv
// Run-length encoder: folds a symbol stream into (symbol, count) records through a
// single-entry output register, splitting runs that reach the maximum count.
`timescale 1ns/1ps
module rle_stream_encoder #(
  parameter int SYM_W  = 8,
  parameter int CNT_W  = 8,
  parameter int STAT_W = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  rle_stream_encoder_if.slave   s,
  output logic                  busy,
  output logic [STAT_W-1:0]     sym_count,
  output logic [STAT_W-1:0]     rec_count
);

  typedef enum logic {ACCUM = 1'b0, FLUSH = 1'b1} state_e;

  localparam logic [CNT_W-1:0] MAX_RUN = '1;
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  function automatic logic run_full(input logic [CNT_W-1:0] cnt);
    return cnt == MAX_RUN;
  endfunction

  state_e             state_q, state_d;
  logic [SYM_W-1:0]   cur_sym_q, cur_sym_d;
  logic [CNT_W-1:0]   cur_cnt_q, cur_cnt_d;
  logic               out_valid_q;
  logic [SYM_W-1:0]   out_sym_q;
  logic [CNT_W-1:0]   out_cnt_q;
  logic               out_last_q;
  logic [STAT_W-1:0]  sym_cnt_q, rec_cnt_q;

  logic               load;
  logic [SYM_W-1:0]   rec_sym_d;
  logic [CNT_W-1:0]   rec_cnt_d;
  logic               rec_last_d;

  logic slot_free, in_ready, beat, out_hs, held, extend;

  assign slot_free = !out_valid_q || s.out_ready;
  assign in_ready  = (state_q == ACCUM) && slot_free;
  assign beat      = s.in_valid && in_ready;
  assign out_hs    = out_valid_q && s.out_ready;
  assign held      = cur_cnt_q != '0;
  // A beat can only grow the held run if it matches and the count has headroom.
  assign extend    = held && (s.in_sym == cur_sym_q) && !run_full(cur_cnt_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ACCUM;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACCUM:   if (beat && s.in_last && held && !extend) state_d = FLUSH;
      FLUSH:   if (slot_free) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  always_comb begin
    cur_sym_d  = cur_sym_q;
    cur_cnt_d  = cur_cnt_q;
    load       = 1'b0;
    rec_sym_d  = cur_sym_q;
    rec_cnt_d  = cur_cnt_q;
    rec_last_d = 1'b0;
    unique case (state_q)
      ACCUM: begin
        if (beat) begin
          if (!s.in_last) begin
            if (!held) begin
              cur_sym_d = s.in_sym;
              cur_cnt_d = ONE;
            end else if (extend) begin
              cur_cnt_d = cur_cnt_q + ONE;
            end else begin
              load      = 1'b1;
              cur_sym_d = s.in_sym;
              cur_cnt_d = ONE;
            end
          end else begin
            load = 1'b1;
            if (!held) begin
              rec_sym_d  = s.in_sym;
              rec_cnt_d  = ONE;
              rec_last_d = 1'b1;
            end else if (extend) begin
              rec_cnt_d  = cur_cnt_q + ONE;
              rec_last_d = 1'b1;
              cur_cnt_d  = '0;
            end else begin
              // Closing record goes out now; the final symbol drains from FLUSH next cycle.
              cur_sym_d = s.in_sym;
              cur_cnt_d = ONE;
            end
          end
        end
      end
      FLUSH: begin
        if (slot_free) begin
          load       = 1'b1;
          rec_last_d = 1'b1;
          cur_cnt_d  = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_sym_q   <= '0;
      cur_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_sym_q   <= '0;
      out_cnt_q   <= '0;
      out_last_q  <= 1'b0;
      sym_cnt_q   <= '0;
      rec_cnt_q   <= '0;
    end else begin
      cur_sym_q <= cur_sym_d;
      cur_cnt_q <= cur_cnt_d;
      if (load) begin
        out_valid_q <= 1'b1;
        out_sym_q   <= rec_sym_d;
        out_cnt_q   <= rec_cnt_d;
        out_last_q  <= rec_last_d;
      end else if (out_hs) begin
        out_valid_q <= 1'b0;
      end
      if (beat)   sym_cnt_q <= sym_cnt_q + STAT_W'(1);
      if (out_hs) rec_cnt_q <= rec_cnt_q + STAT_W'(1);
    end
  end

  assign s.in_ready  = in_ready;
  assign s.out_valid = out_valid_q;
  assign s.out_sym   = out_sym_q;
  assign s.out_cnt   = out_cnt_q;
  assign s.out_last  = out_last_q;
  assign busy        = held || out_valid_q || (state_q == FLUSH);
  assign sym_count   = sym_cnt_q;
  assign rec_count   = rec_cnt_q;

endmodule

// File: tb/tb_rle_stream_encoder.sv
// Scoreboard bench for rle_stream_encoder: directed streams on an 8-bit-count and a 4-bit-count instance.
`timescale 1ns/1ps
module tb_rle_stream_encoder;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  rle_stream_encoder_if #(.SYM_W(8), .CNT_W(8)) if8();
  rle_stream_encoder_if #(.SYM_W(8), .CNT_W(4)) if4();

  logic        busy8, busy4;
  logic [31:0] sc8, rc8, sc4, rc4;

  rle_stream_encoder #(.SYM_W(8), .CNT_W(8), .STAT_W(32)) dut8 (
    .clk(clk), .reset_n(reset_n), .s(if8.slave),
    .busy(busy8), .sym_count(sc8), .rec_count(rc8));

  rle_stream_encoder #(.SYM_W(8), .CNT_W(4), .STAT_W(32)) dut4 (
    .clk(clk), .reset_n(reset_n), .s(if4.slave),
    .busy(busy4), .sym_count(sc4), .rec_count(rc4));

  typedef struct packed {
    logic [7:0] sym;
    logic [7:0] cnt;
    logic       last;
  } rec_t;

  rec_t q8[$];
  rec_t q4[$];
  rec_t act8, act4;
  int checks = 0;
  int errors = 0;
  int beats8 = 0, hs8 = 0;

  localparam logic [7:0] SA = 8'hA1;
  localparam logic [7:0] SB = 8'hB2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitors: compare every presented record against the queue head; pop on handshake.
  always @(negedge clk) begin
    if (reset_n && if8.out_valid) begin
      act8 = '{sym: if8.out_sym, cnt: if8.out_cnt, last: if8.out_last};
      if (q8.size() == 0) begin
        if (if8.out_ready) begin
          checks++; errors++; hs8++;
          $display("FAIL rec8_unexpected: got %0h/%0d/%0d expected none", act8.sym, act8.cnt, act8.last);
        end
      end else begin
        checks++;
        if (act8 !== q8[0]) begin
          errors++;
          $display("FAIL rec8: got %0h/%0d/%0d expected %0h/%0d/%0d",
                   act8.sym, act8.cnt, act8.last, q8[0].sym, q8[0].cnt, q8[0].last);
        end
        if (if8.out_ready) begin
          void'(q8.pop_front());
          hs8++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && if4.out_valid) begin
      act4 = '{sym: if4.out_sym, cnt: 8'(if4.out_cnt), last: if4.out_last};
      if (q4.size() == 0) begin
        if (if4.out_ready) begin
          checks++; errors++;
          $display("FAIL rec4_unexpected: got %0h/%0d/%0d expected none", act4.sym, act4.cnt, act4.last);
        end
      end else begin
        checks++;
        if (act4 !== q4[0]) begin
          errors++;
          $display("FAIL rec4: got %0h/%0d/%0d expected %0h/%0d/%0d",
                   act4.sym, act4.cnt, act4.last, q4[0].sym, q4[0].cnt, q4[0].last);
        end
        if (if4.out_ready) void'(q4.pop_front());
      end
    end
  end

  task automatic send8(input logic [7:0] sym, input logic last);
    int n = 0;
    if8.in_valid = 1'b1; if8.in_sym = sym; if8.in_last = last;
    @(negedge clk);
    while (!if8.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL send8_timeout: got in_ready=0 expected 1 within 200 cycles");
    end else beats8++;
    @(posedge clk); #1;
    if8.in_valid = 1'b0; if8.in_last = 1'b0;
  endtask

  task automatic send4(input logic [7:0] sym, input logic last);
    int n = 0;
    if4.in_valid = 1'b1; if4.in_sym = sym; if4.in_last = last;
    @(negedge clk);
    while (!if4.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL send4_timeout: got in_ready=0 expected 1 within 200 cycles");
    end
    @(posedge clk); #1;
    if4.in_valid = 1'b0; if4.in_last = 1'b0;
  endtask

  task automatic drain8(input string name);
    int n = 0;
    while ((q8.size() != 0 || if8.out_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_drained"}, 32'(q8.size()), 32'd0);
  endtask

  task automatic drain4(input string name);
    int n = 0;
    while ((q4.size() != 0 || if4.out_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_drained"}, 32'(q4.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before 2ms");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    if8.in_valid = 1'b0; if8.in_sym = '0; if8.in_last = 1'b0; if8.out_ready = 1'b0;
    if4.in_valid = 1'b0; if4.in_sym = '0; if4.in_last = 1'b0; if4.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(if8.out_valid), 32'd0);
    chk("rst_out_sym",   32'(if8.out_sym),   32'd0);
    chk("rst_out_cnt",   32'(if8.out_cnt),   32'd0);
    chk("rst_out_last",  32'(if8.out_last),  32'd0);
    chk("rst_sym_count", sc8, 32'd0);
    chk("rst_rec_count", rc8, 32'd0);
    chk("rst_busy",      32'(busy8), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // A,A,A,B(last): mismatching last symbol forces a one-cycle FLUSH
    if8.out_ready = 1'b1;
    q8.push_back('{sym: SA, cnt: 8'd3, last: 1'b0});
    q8.push_back('{sym: SB, cnt: 8'd1, last: 1'b1});
    send8(SA, 1'b0); send8(SA, 1'b0); send8(SA, 1'b0);
    chk("t1_busy_held", 32'(busy8), 32'd1);
    send8(SB, 1'b1);
    chk("t1_flush_in_ready", 32'(if8.in_ready), 32'd0);
    chk("t1_first_rec_valid", 32'(if8.out_valid), 32'd1);
    drain8("t1");
    chk("t1_sym_count", sc8, 32'd4);
    chk("t1_rec_count", rc8, 32'd2);
    chk("t1_busy_idle", 32'(busy8), 32'd0);

    // Single beat with last
    q8.push_back('{sym: 8'h11, cnt: 8'd1, last: 1'b1});
    send8(8'h11, 1'b1);
    chk("t3_valid_next_cycle", 32'(if8.out_valid), 32'd1);
    chk("t3_busy", 32'(busy8), 32'd1);
    @(posedge clk); #1;
    chk("t3_busy_after_hs", 32'(busy8), 32'd0);
    drain8("t3");

    // Alternating 1,2,1,2(last) with downstream stalled 10 cycles
    if8.out_ready = 1'b0;
    q8.push_back('{sym: 8'd1, cnt: 8'd1, last: 1'b0});
    q8.push_back('{sym: 8'd2, cnt: 8'd1, last: 1'b0});
    q8.push_back('{sym: 8'd1, cnt: 8'd1, last: 1'b0});
    q8.push_back('{sym: 8'd2, cnt: 8'd1, last: 1'b1});
    fork
      begin
        send8(8'd1, 1'b0); send8(8'd2, 1'b0); send8(8'd1, 1'b0); send8(8'd2, 1'b1);
      end
      begin
        repeat (4) @(posedge clk);
        #2;
        chk("t4_in_ready_stalled", 32'(if8.in_ready), 32'd0);
        chk("t4_out_valid_stalled", 32'(if8.out_valid), 32'd1);
        repeat (6) @(posedge clk);
        #1 if8.out_ready = 1'b1;
      end
    join
    drain8("t4");
    chk("t4_sym_count", sc8, 32'(beats8));
    chk("t4_rec_count", rc8, 32'(hs8));

    // 7 x 0xFF, last matches: single record, no FLUSH
    q8.push_back('{sym: 8'hFF, cnt: 8'd7, last: 1'b1});
    for (int i = 0; i < 7; i++) send8(8'hFF, i == 6);
    chk("t5_no_flush_in_ready", 32'(if8.in_ready), 32'd1);
    chk("t5_rec_valid", 32'(if8.out_valid), 32'd1);
    drain8("t5");

    // CNT_W=4: 20 x 0x5A splits at 15
    if4.out_ready = 1'b1;
    q4.push_back('{sym: 8'h5A, cnt: 8'd15, last: 1'b0});
    q4.push_back('{sym: 8'h5A, cnt: 8'd5,  last: 1'b1});
    for (int i = 0; i < 20; i++) send4(8'h5A, i == 19);
    drain4("t2");
    chk("t2_sym_count", sc4, 32'd20);
    chk("t2_rec_count", rc4, 32'd2);

    // Reset mid-stream with a record pending
    if8.out_ready = 1'b0;
    send8(SA, 1'b0); send8(SA, 1'b0); send8(SB, 1'b0);
    chk("t6_pending_valid", 32'(if8.out_valid), 32'd1);
    #3 reset_n = 1'b0;
    #1;
    chk("t6_rst_out_valid", 32'(if8.out_valid), 32'd0);
    chk("t6_rst_sym_count", sc8, 32'd0);
    chk("t6_rst_rec_count", rc8, 32'd0);
    chk("t6_rst_busy", 32'(busy8), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    beats8 = 0; hs8 = 0;
    if8.out_ready = 1'b1;
    q8.push_back('{sym: 8'h09, cnt: 8'd1, last: 1'b1});
    send8(8'h09, 1'b1);
    drain8("t6");
    chk("t6_sym_count", sc8, 32'd1);
    chk("t6_rec_count", rc8, 32'd1);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rle_stream_encoder.md
Name: rle_stream_encoder

Overview:
- Parametrised run-length encoder stage for the RLE AFU datapath; sits between the host-read line unpacker and the host-write line packer.
- Consumes a valid/ready symbol stream with end-of-stream marker; emits (symbol, run length) records on a valid/ready output with a single-entry output register.
- Run length saturates at a parameterised maximum, splitting long runs; provides symbol/record counters for CSR readback.

Parameters:
- SYM_W, 8, symbol width in bits (>=1)
- CNT_W, 8, run-length field width; MAX_RUN = 2^CNT_W - 1 (>=2)
- STAT_W, 32, width of statistics counters

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  input symbol valid
- in_ready  out  1  encoder accepts symbol this cycle
- in_sym  in  SYM_W  input symbol
- in_last  in  1  final symbol of stream
- out_valid  out  1  record valid
- out_ready  in  1  downstream accepts record
- out_sym  out  SYM_W  run symbol
- out_cnt  out  CNT_W  run length, 1..MAX_RUN
- out_last  out  1  final record of stream
- busy  out  1  run held or record pending or FLUSH state
- sym_count  out  STAT_W  accepted input beats since reset, wraps
- rec_count  out  STAT_W  output handshakes since reset, wraps

Behaviour:
- Reset clock/reset: single clock clk; reset_n asynchronous active-low; all state/outputs cleared on assertion, released synchronously to clk by upstream reset logic.
- Reset values: out_valid=0, out_sym=0, out_cnt=0, out_last=0, sym_count=0, rec_count=0, state=ACCUM, held run empty (cur_cnt=0); busy=0.
- Internal: held run cur_sym/cur_cnt (cur_cnt=0 = empty); output register; states ACCUM, FLUSH.
- slot_free = !out_valid || out_ready. in_ready = (state==ACCUM) && slot_free. Input beat = in_valid && in_ready.
- Output register clears out_valid on out_valid&&out_ready unless reloaded same cycle; holds contents stable while out_valid && !out_ready.
- ACCUM, beat, in_last=0:
  - cur_cnt==0: cur_sym<=in_sym, cur_cnt<=1; no output.
  - in_sym==cur_sym and cur_cnt<MAX_RUN: cur_cnt<=cur_cnt+1.
  - else (mismatch or saturated): load output (cur_sym,cur_cnt,last=0); cur_sym<=in_sym, cur_cnt<=1.
- ACCUM, beat, in_last=1:
  - cur_cnt==0: output (in_sym,1,last=1).
  - match and cur_cnt<MAX_RUN: output (cur_sym,cur_cnt+1,last=1); cur_cnt<=0.
  - else: output (cur_sym,cur_cnt,last=0); cur_sym<=in_sym, cur_cnt<=1; state<=FLUSH.
- FLUSH: in_ready=0; when slot_free: output (cur_sym,cur_cnt,last=1), cur_cnt<=0, state<=ACCUM.
- Latency: a record is valid the cycle after the beat that terminates its run; zero-bubble throughput of one symbol/cycle when out_ready held high, except one stall cycle for FLUSH.
- Arithmetic: out_cnt never 0, never exceeds MAX_RUN; run of N identical symbols yields floor(N/MAX_RUN) records of MAX_RUN plus a remainder record if nonzero.
- Counters: sym_count += 1 per input beat; rec_count += 1 per out_valid&&out_ready; both wrap modulo 2^STAT_W.
- Held run with no in_last stays held indefinitely (no timeout).
- Back-to-back streams: next stream's first beat accepted in the cycle after the last record loads (ACCUM, slot_free).
- in_valid with in_ready=0: no state change; upstream holds data.
- Reset mid-stream: held run and pending record discarded; no partial record emitted after release.

Test Plan:
- Stream A,A,A,B(last), SYM_W=8, out_ready=1 -> records (A,3,0),(B,1,1); FLUSH stall 1 cycle; sym_count=4, rec_count=2.
- CNT_W=4, 20 x 0x5A, last on 20th -> (0x5A,15,0),(0x5A,5,1); out_cnt never >15.
- Single beat 0x11 with in_last -> (0x11,1,1) one cycle later; busy returns 0 after handshake.
- Alternating 1,2,1,2(last) with out_ready=0 for 10 cycles then 1 -> in_ready drops after first record load; records (1,1,0),(2,1,0),(1,1,0),(2,1,1) in order, contents stable while stalled.
- 7 x 0xFF, last on 7th matching, CNT_W=8 -> single record (0xFF,7,1), no FLUSH cycle.
- Assert reset_n=0 mid-run after 3 beats and out_valid=1 -> out_valid=0, counters 0 immediately; new stream 9(last) after release -> (9,1,1) only.
